proc_frame_ctrl: RTL and testbench

Frame-level controller for the `image_process` datapath. Accepts processing configuration from a host-side request/acknowledge port, holds it in a pending register, and commits it to the datapath only on a VGA frame boundary so no frame is processed with mixed settings. Also decimates processing (process one frame in every `skip+1`), counts frames, and flags a lost VSYNC. Sits between the `gensync` timing outputs and the `image_process` control inputs.

---
 rtl/proc_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_proc_frame_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_frame_ctrl.sv
// Frame-level controller: latches host configuration and commits it to the image datapath on VSYNC frame boundaries.
// Optional VSYNC-loss watchdog enabled by defining PFC_VS_WATCHDOG_EN.
module proc_frame_ctrl #(
    parameter int THR_W = 8,
    parameter int CNT_W = 16,
    parameter int WD_W  = 20
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             vga_vs,
    input  logic             cfg_req,
    input  logic [1:0]       cfg_mode,
    input  logic [THR_W-1:0] cfg_thr,
    input  logic [3:0]       cfg_skip,
    output logic             cfg_ack,
    output logic             cfg_busy,
    output logic [1:0]       mode,
    output logic [THR_W-1:0] thr,
    output logic             proc_en,
    output logic             frame_start,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             wd_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SKIP = 2'd2
    } state_t;

    state_t state, state_nx;

    logic             vs_q;
    logic             fb;
    logic             commit;
    logic             capture;
    logic             wd_hit;
    logic [3:0]       skip;
    logic [3:0]       skip_eff;
    logic [3:0]       skip_cnt, skip_cnt_nx;
    logic [1:0]       pend_mode;
    logic [THR_W-1:0] pend_thr;
    logic [3:0]       pend_skip;

    // A pending request can only be captured once the previous one has been committed.
    assign fb       = vga_vs & ~vs_q;
    assign commit   = fb & cfg_busy;
    assign capture  = cfg_req & ~cfg_busy;
    assign skip_eff = commit ? pend_skip : skip;

    always_comb begin
        state_nx    = state;
        skip_cnt_nx = skip_cnt;
        if (fb) begin
            case (state)
                IDLE: begin
                    state_nx    = RUN;
                    skip_cnt_nx = 4'd0;
                end
                RUN: begin
                    if (skip_eff != 4'd0) begin
                        state_nx    = SKIP;
                        skip_cnt_nx = 4'd1;
                    end
                end
                SKIP: begin
                    if (skip_cnt == skip_eff) begin
                        state_nx = RUN;
                    end else begin
                        skip_cnt_nx = skip_cnt + 4'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (wd_hit) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            skip_cnt <= 4'd0;
        end else begin
            state    <= state_nx;
            skip_cnt <= skip_cnt_nx;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vs_q        <= 1'b1;
            cfg_ack     <= 1'b0;
            cfg_busy    <= 1'b0;
            pend_mode   <= 2'd0;
            pend_thr    <= '0;
            pend_skip   <= 4'd0;
            mode        <= 2'd0;
            thr         <= '0;
            skip        <= 4'd0;
            proc_en     <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            vs_q        <= vga_vs;
            cfg_ack     <= capture;
            frame_start <= fb;
            proc_en     <= (state_nx == RUN);
            if (fb) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (commit) begin
                mode     <= pend_mode;
                thr      <= pend_thr;
                skip     <= pend_skip;
                cfg_busy <= 1'b0;
            end else if (capture) begin
                pend_mode <= cfg_mode;
                pend_thr  <= cfg_thr;
                pend_skip <= cfg_skip;
                cfg_busy  <= 1'b1;
            end
        end
    end

`ifdef PFC_VS_WATCHDOG_EN
    logic [WD_W-1:0] wd_cnt;

    // Saturating count of cycles since the last boundary; all-ones means VSYNC is lost.
    assign wd_hit = (wd_cnt == {WD_W{1'b1}});

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            wd_err <= 1'b0;
        end else begin
            if (fb) begin
                wd_cnt <= '0;
            end else if (!wd_hit) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_hit) begin
                wd_err <= 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_proc_frame_ctrl.sv
// Scoreboard bench for proc_frame_ctrl: a frame-level reference model queues expected acks and frame results.
`timescale 1ns/1ps
module tb_proc_frame_ctrl;

    logic        vga_clk;
    logic        reset;
    logic        vga_vs;
    logic        cfg_req;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_thr;
    logic [3:0]  cfg_skip;
    logic        cfg_ack;
    logic        cfg_busy;
    logic [1:0]  mode;
    logic [7:0]  thr;
    logic        proc_en;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        wd_err;

    proc_frame_ctrl #(.THR_W(8), .CNT_W(16), .WD_W(20)) dut (
        .vga_clk(vga_clk), .reset(reset), .vga_vs(vga_vs),
        .cfg_req(cfg_req), .cfg_mode(cfg_mode), .cfg_thr(cfg_thr), .cfg_skip(cfg_skip),
        .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .mode(mode), .thr(thr),
        .proc_en(proc_en), .frame_start(frame_start), .frame_cnt(frame_cnt), .wd_err(wd_err)
    );

    typedef struct {
        int          cyc;
        logic [1:0]  mode;
        logic [7:0]  thr;
        logic        proc;
        logic [15:0] cnt;
    } frame_t;

    frame_t fq[$];
    int     aq[$];
    int     cyc = 0;
    int     tests = 0;
    int     failed = 0;

    // Reference model state, kept in terms of frames rather than FSM states.
    logic        m_vs_prev;
    bit          m_idle;
    bit          m_busy;
    logic [1:0]  m_mode, p_mode;
    logic [7:0]  m_thr, p_thr;
    logic [3:0]  m_skip, p_skip;
    logic [3:0]  m_since;
    logic [15:0] m_cnt;
    bit          host_req;
    bit          drop_req;

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_vs_prev = 1'b1; m_idle = 1'b1; m_busy = 1'b0;
        m_mode = 2'd0; m_thr = 8'd0; m_skip = 4'd0; m_since = 4'd0; m_cnt = 16'd0;
        drop_req = 1'b0;
    endtask

    task automatic issue_req(input logic [1:0] md, input logic [7:0] th, input logic [3:0] sk);
        cfg_mode = md; cfg_thr = th; cfg_skip = sk;
        host_req = 1'b1; drop_req = 1'b0;
    endtask

    // Drive one cycle (called at a negedge) and predict what the next rising edge must produce.
    task automatic applyStimulus(input logic vs_in);
        bit fb;
        bit proc;
        frame_t f;
        if (drop_req) begin
            host_req = 1'b0; drop_req = 1'b0;
        end
        vga_vs  = vs_in;
        cfg_req = host_req;
        fb = vs_in && !m_vs_prev;
        m_vs_prev = vs_in;
        if (fb) begin
            if (m_busy) begin
                m_mode = p_mode; m_thr = p_thr; m_skip = p_skip; m_busy = 1'b0;
            end
            if (m_idle || m_since == m_skip) begin
                proc = 1'b1; m_since = 4'd0; m_idle = 1'b0;
            end else begin
                proc = 1'b0; m_since = m_since + 4'd1;
            end
            m_cnt = m_cnt + 16'd1;
            f.cyc = cyc + 1; f.mode = m_mode; f.thr = m_thr; f.proc = proc; f.cnt = m_cnt;
            fq.push_back(f);
        end else if (host_req && !m_busy) begin
            p_mode = cfg_mode; p_thr = cfg_thr; p_skip = cfg_skip; m_busy = 1'b1;
            aq.push_back(cyc + 1);
            drop_req = 1'b1;
        end
        @(negedge vga_clk);
    endtask

    // Sync-low part first, then the visible part; the first high cycle is the frame boundary.
    task automatic run_frame(input int hi, input int lo, input bit rnd);
        for (int i = 0; i < lo; i++) begin
            if (rnd && !host_req && $urandom_range(0, 11) == 0)
                issue_req(2'($urandom), 8'($urandom), 4'($urandom_range(0, 4)));
            applyStimulus(1'b0);
        end
        for (int i = 0; i < hi; i++) begin
            if (rnd && !host_req && (i != 0 || m_busy) && $urandom_range(0, 11) == 0)
                issue_req(2'($urandom), 8'($urandom), 4'($urandom_range(0, 4)));
            applyStimulus(1'b1);
        end
    endtask

    // Monitor: pop the expected record whenever the DUT presents an ack or a frame start.
    always @(negedge vga_clk) begin
        if (!reset) begin
            if (cfg_ack) begin
                if (aq.size() == 0) begin
                    checkOutput("ack_unexpected", 32'(cfg_ack), 32'd0);
                end else begin
                    checkOutput("ack_cycle", 32'(cyc), 32'(aq[0]));
                    checkOutput("ack_busy", 32'(cfg_busy), 32'd1);
                    void'(aq.pop_front());
                end
            end else if (aq.size() > 0 && aq[0] <= cyc) begin
                checkOutput("ack_missing", 32'(cfg_ack), 32'd1);
                void'(aq.pop_front());
            end
            if (frame_start) begin
                if (fq.size() == 0) begin
                    checkOutput("frame_unexpected", 32'(frame_start), 32'd0);
                end else begin
                    checkOutput("frame_cycle", 32'(cyc), 32'(fq[0].cyc));
                    checkOutput("frame_mode", 32'(mode), 32'(fq[0].mode));
                    checkOutput("frame_thr", 32'(thr), 32'(fq[0].thr));
                    checkOutput("frame_proc_en", 32'(proc_en), 32'(fq[0].proc));
                    checkOutput("frame_cnt", 32'(frame_cnt), 32'(fq[0].cnt));
                    checkOutput("frame_busy", 32'(cfg_busy), 32'd0);
                    void'(fq.pop_front());
                end
            end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                checkOutput("frame_missing", 32'(frame_start), 32'd1);
                void'(fq.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; vga_vs = 1'b1; cfg_req = 1'b0;
        cfg_mode = 2'd0; cfg_thr = 8'd0; cfg_skip = 4'd0;
        host_req = 1'b0;
        model_reset();
        repeat (3) @(negedge vga_clk);
        reset = 1'b0;
        repeat (3) applyStimulus(1'b1);
        checkOutput("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        checkOutput("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        checkOutput("rst_mode", 32'(mode), 32'd0);
        checkOutput("rst_thr", 32'(thr), 32'd0);
        checkOutput("rst_proc_en", 32'(proc_en), 32'd0);
        checkOutput("rst_frame_start", 32'(frame_start), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_wd_err", 32'(wd_err), 32'd0);

        // Request mid-frame, committed by the first boundary.
        issue_req(2'd2, 8'h80, 4'd0);
        repeat (6) applyStimulus(1'b1);
        checkOutput("req_busy", 32'(cfg_busy), 32'd1);
        checkOutput("req_proc_en_idle", 32'(proc_en), 32'd0);
        run_frame(30, 3, 1'b0);

        // Decimation by 3.
        issue_req(2'd1, 8'h11, 4'd2);
        repeat (4) applyStimulus(1'b1);
        for (int i = 0; i < 8; i++) run_frame(24, 3, 1'b0);

        // Second request stalls until the first commits.
        issue_req(2'd3, 8'h40, 4'd0);
        repeat (4) applyStimulus(1'b1);
        issue_req(2'd0, 8'h22, 4'd1);
        run_frame(24, 3, 1'b0);
        run_frame(24, 3, 1'b0);
        run_frame(24, 3, 1'b0);

        // Request presented on the boundary edge while another is pending.
        issue_req(2'd2, 8'h33, 4'd0);
        repeat (4) applyStimulus(1'b1);
        repeat (3) applyStimulus(1'b0);
        issue_req(2'd1, 8'h44, 4'd3);
        repeat (20) applyStimulus(1'b1);
        for (int i = 0; i < 6; i++) run_frame(20, 2, 1'b0);

        for (int i = 0; i < 60; i++) run_frame($urandom_range(12, 40), $urandom_range(1, 4), 1'b1);

        // Reset with an uncommitted request; a request held through reset is taken right after.
        host_req = 1'b0;
        repeat (50) applyStimulus(1'b1);
        issue_req(2'd2, 8'h55, 4'd1);
        repeat (5) applyStimulus(1'b1);
        reset = 1'b1;
        model_reset();
        issue_req(2'd3, 8'h99, 4'd0);
        cfg_req = 1'b1;
        repeat (2) @(negedge vga_clk);
        checkOutput("midrst_busy", 32'(cfg_busy), 32'd0);
        checkOutput("midrst_mode", 32'(mode), 32'd0);
        checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("midrst_proc_en", 32'(proc_en), 32'd0);
        reset = 1'b0;
        repeat (5) applyStimulus(1'b1);
        for (int i = 0; i < 3; i++) run_frame(20, 3, 1'b0);

`ifdef PFC_VS_WATCHDOG_EN
        repeat ((1 << 20) + 8) applyStimulus(1'b1);
        checkOutput("wd_err_set", 32'(wd_err), 32'd1);
        checkOutput("wd_proc_en", 32'(proc_en), 32'd0);
        m_idle = 1'b1;
        for (int i = 0; i < 2; i++) run_frame(20, 3, 1'b0);
        checkOutput("wd_err_sticky", 32'(wd_err), 32'd1);
`else
        checkOutput("wd_err_tied", 32'(wd_err), 32'd0);
`endif

        repeat (4) applyStimulus(1'b1);
        checkOutput("ack_q_drained", 32'(aq.size()), 32'd0);
        checkOutput("frame_q_drained", 32'(fq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
